// File: rtl/div_pkg.sv
// Shared types and sizing for the restoring shift-subtract divider control path.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// Handshake and datapath-strobe bundle between div_ctrl and its surroundings.
interface div_ctrl_if;

  logic       start;
  logic       abort;
  logic       m_zero;
  logic       SB;
  logic       loadA;
  logic       loadM;
  logic       loadD;
  logic       shiftA;
  logic       shiftQ;
  logic       shiftD;
  logic       InitA;
  logic       InitQ;
  logic       Q0sel;
  logic [3:0] MSB_D;
  logic       busy;
  logic       done;
  logic       dbz;

  // Wrapper/datapath side: requests divisions and reports the borrow flag.
  modport master (
    output start, abort, m_zero, SB,
    input  loadA, loadM, loadD, shiftA, shiftQ, shiftD, InitA, InitQ, Q0sel, MSB_D,
    input  busy, done, dbz
  );

  // Controller side.
  modport slave (
    input  start, abort, m_zero, SB,
    output loadA, loadM, loadD, shiftA, shiftQ, shiftD, InitA, InitQ, Q0sel, MSB_D,
    output busy, done, dbz
  );

endinterface

// File: rtl/div_ctrl.sv
// Sequencer for the restoring divider: one quotient bit per clock, start/busy/done handshake
// and a divide-by-zero flag. Strobes are decoded from state so an async reset drops them at once.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH   = DIV_WIDTH,
  parameter int unsigned CNT_W   = DIV_CNT_W,
  parameter int unsigned MSB_IDX = WIDTH - 1
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dbz_q, dbz_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dbz_d   = dbz_q;
    if (bus.abort) begin
      // Abort wins over everything; dbz deliberately keeps its last value.
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = LOAD;
            dbz_d   = bus.m_zero;
          end
        end
        LOAD: begin
          count_d = '0;
          state_d = dbz_q ? DONE : ITER;
        end
        ITER: begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LastCnt) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.loadA  = 1'b0;
    bus.loadM  = 1'b0;
    bus.loadD  = 1'b0;
    bus.shiftA = 1'b0;
    bus.shiftQ = 1'b0;
    bus.shiftD = 1'b0;
    bus.InitA  = 1'b0;
    bus.InitQ  = 1'b0;
    bus.Q0sel  = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state_q)
      LOAD: begin
        bus.loadD = 1'b1;
        bus.loadM = 1'b1;
        bus.InitA = 1'b1;
        bus.InitQ = 1'b1;
        bus.busy  = 1'b1;
      end
      ITER: begin
        // Borrow selects restore (keep shifted A, bit 0) versus commit the subtraction (bit 1).
        bus.shiftQ = 1'b1;
        bus.shiftD = 1'b1;
        bus.loadA  = ~bus.SB;
        bus.shiftA = bus.SB;
        bus.Q0sel  = bus.SB;
        bus.busy   = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.MSB_D = 4'(MSB_IDX);
  assign bus.dbz   = dbz_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: a behavioural restoring datapath answers the strobes, a timing model
// predicts every control output per cycle, and directed divisions pin results and latencies.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int unsigned W = DIV_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl #(
    .WIDTH  (W),
    .CNT_W  (DIV_CNT_W),
    .MSB_IDX(W - 1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural datapath: A:Q restoring divider driven purely by the strobes.
  logic [15:0] din, min, d_reg, m_reg, q_reg;
  logic [16:0] a_reg, a_sh;

  assign a_sh       = {a_reg[15:0], d_reg[bus.MSB_D]};
  assign bus.SB     = (a_sh < {1'b0, m_reg});
  assign bus.m_zero = (min == 16'd0);

  always @(posedge clk) begin
    if (bus.loadD) d_reg <= din;
    else if (bus.shiftD) d_reg <= {d_reg[14:0], 1'b0};
    if (bus.loadM) m_reg <= min;
    if (bus.InitA) a_reg <= '0;
    else if (bus.loadA) a_reg <= a_sh - {1'b0, m_reg};
    else if (bus.shiftA) a_reg <= a_sh;
    if (bus.InitQ) q_reg <= '0;
    else if (bus.shiftQ) q_reg <= {q_reg[14:0], ~bus.Q0sel};
  end

  // Timing model: a division accepted at some edge occupies a window of cycles measured from it.
  int cyc, t0, rel, done_rel;
  bit active, zero, dbz_m, model_idle;

  assign rel        = cyc - t0;
  assign done_rel   = zero ? 1 : int'(W) + 1;
  assign model_idle = !active || (rel > done_rel);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc    <= 0;
      t0     <= 0;
      active <= 1'b0;
      zero   <= 1'b0;
      dbz_m  <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (bus.abort) begin
        active <= 1'b0;
      end else if (bus.start && model_idle) begin
        active <= 1'b1;
        t0     <= cyc + 1;
        zero   <= bus.m_zero;
        dbz_m  <= bus.m_zero;
      end
    end
  end

  bit in_load, in_iter, in_done;
  assign in_load = active && (rel == 0);
  assign in_iter = active && !zero && (rel >= 1) && (rel <= int'(W));
  assign in_done = active && (rel == done_rel);

  logic [15:0] got_v, exp_v;
  assign got_v = {bus.loadA, bus.loadM, bus.loadD, bus.shiftA, bus.shiftQ, bus.shiftD,
                  bus.InitA, bus.InitQ, bus.Q0sel, bus.busy, bus.done, bus.dbz, bus.MSB_D};
  assign exp_v = {in_iter & ~bus.SB, in_load, in_load, in_iter & bus.SB, in_iter, in_iter,
                  in_load, in_load, in_iter & bus.SB, in_load | in_iter, in_done, dbz_m, 4'd15};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic run_div(input string name, input logic [15:0] d, input logic [15:0] m,
                         input int exp_lat, input logic [15:0] exp_q, input logic [15:0] exp_r,
                         input logic exp_dbz, input int exp_la, input int exp_sa);
    int n, busy_n, la_n, sa_n;
    bit seen;
    @(posedge clk);
    #1;
    din       = d;
    min       = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0; busy_n = 0; la_n = 0; sa_n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.busy) busy_n++;
      if (bus.loadA) la_n++;
      if (bus.shiftA) sa_n++;
      if (bus.done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    check({name, "_quotient"}, 32'(q_reg), 32'(exp_q));
    check({name, "_remainder"}, 32'(a_reg[15:0]), 32'(exp_r));
    check({name, "_dbz"}, 32'(bus.dbz), 32'(exp_dbz));
    check({name, "_loadA_cycles"}, 32'(la_n), 32'(exp_la));
    check({name, "_shiftA_cycles"}, 32'(sa_n), 32'(exp_sa));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    din       = '0;
    min       = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst) check("cycle_model", 32'(got_v), 32'(exp_v));
      end
    join_none

    #2;
    check("in_reset_outputs", 32'(got_v), 32'(16'h000F));
    #20 rst = 1'b1;
    @(negedge clk);
    check("reset_state", 32'(got_v), 32'(16'h000F));

    run_div("d100_m7", 16'd100, 16'd7, 18, 16'd14, 16'd2, 1'b0, 3, 13);
    run_div("dffff_m1", 16'hFFFF, 16'd1, 18, 16'hFFFF, 16'd0, 1'b0, 16, 0);
    run_div("d5_m9", 16'd5, 16'd9, 18, 16'd0, 16'd5, 1'b0, 0, 16);
    run_div("m_zero", 16'd1234, 16'd0, 2, 16'd0, 16'd0, 1'b1, 0, 0);
    repeat (3) @(negedge clk);
    check("dbz_hold", 32'(bus.dbz), 32'd1);

    // Abort during ITER cycle 7.
    @(posedge clk);
    #1;
    din       = 16'd1000;
    min       = 16'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_div("d50_m6", 16'd50, 16'd6, 18, 16'd8, 16'd2, 1'b0, 1, 15);

    // Asynchronous reset during ITER cycle 3.
    @(posedge clk);
    #1;
    din       = 16'd1000;
    min       = 16'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_async_outputs", 32'(got_v), 32'(16'h000F));
    @(negedge clk);
    #2 rst = 1'b1;
    run_div("d9_m3", 16'd9, 16'd3, 18, 16'd3, 16'd0, 1'b0, 2, 14);

    // start held high: back-to-back divisions, one IDLE cycle between done and LOAD.
    @(posedge clk);
    #1;
    din       = 16'd100;
    min       = 16'd7;
    bus.start = 1'b1;
    @(posedge clk);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("b2b_done_count", 32'(ndone), 32'd2);
    bus.start = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("b2b_quotient", 32'(q_reg), 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
